// File: rtl/noise_iir_mc_pkg.sv
// noise_iir_pkg: shared widths, defaults and FSM encoding for the multichannel noise IIR.
package noise_iir_pkg;
    localparam int BW_W = 5;
    localparam int DSZ_DEF = 18;
    localparam int Q_DEF = 31;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/noise_iir_mc_sat.sv
// sat: two's-complement saturation from isz bits down to osz bits.
module sat #(
    parameter int isz = 32,
    parameter int osz = 16
) (
    input  logic [isz-1:0] din,
    output logic [osz-1:0] dout
);
    logic ovf;
    always_comb begin
        ovf = din[isz-1:osz-1] != {(isz-osz+1){din[isz-1]}};
        dout = ovf ? {din[isz-1], {(osz-1){~din[isz-1]}}} : din[osz-1:0];
    end
endmodule

// File: rtl/noise_iir_mc.sv
// noise_iir_mc: time-multiplexed first-order leaky-integrator IIR over NCH channels, one channel per cycle.
module noise_iir_mc
    import noise_iir_pkg::*;
#(
    parameter int DSZ = DSZ_DEF,
    parameter int Q = Q_DEF,
    parameter int NCH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_stb,
    input  logic [NCH*DSZ-1:0]   in,
    input  logic [NCH*BW_W-1:0]  bw,
    input  logic [NCH-1:0]       clr,
    output logic [NCH*DSZ-1:0]   out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int ISZ = DSZ + Q;
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    state_t state;
    logic [CW-1:0] ch;
    logic [NCH*DSZ-1:0] in_r;
    logic [NCH*BW_W-1:0] bw_r;
    logic [NCH-1:0] clr_r;
    logic signed [ISZ-1:0] acc [NCH];
    logic signed [DSZ-1:0] shadow [NCH];
    logic [NCH*DSZ-1:0] frame;
    logic [BW_W-1:0] bw_k;
    logic [7:0] coef;
    logic signed [DSZ-1:0] in_k, y;
    logic signed [ISZ-1:0] acc_k, fb, sum_sat, acc_nx, y_wide;
    logic signed [ISZ:0] sum;
    always_comb begin
        bw_k = bw_r[int'(ch)*BW_W +: BW_W];
        in_k = in_r[int'(ch)*DSZ +: DSZ];
        coef = (int'(bw_k) <= Q) ? 8'(Q - int'(bw_k)) : 8'd0;
        acc_k = acc[ch];
        fb = acc_k >>> coef;
        sum = {{(Q+1){in_k[DSZ-1]}}, in_k} + {acc_k[ISZ-1], acc_k} - {fb[ISZ-1], fb};
        acc_nx = clr_r[ch] ? '0 : sum_sat;
        y_wide = acc_nx >>> coef;
    end
    sat #(.isz(ISZ+1), .osz(ISZ)) u_sat_acc (.din(sum), .dout(sum_sat));
    sat #(.isz(ISZ), .osz(DSZ)) u_sat_out (.din(y_wide), .dout(y));
    // Last channel's result bypasses the shadow so the whole frame lands on out in one edge.
    always_comb begin
        frame = '0;
        for (int k = 0; k < NCH; k++)
            frame[k*DSZ +: DSZ] = (k == int'(ch)) ? y : shadow[k];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch <= '0;
            in_r <= '0;
            bw_r <= '0;
            clr_r <= '0;
            out <= '0;
            out_valid <= 1'b0;
            busy <= 1'b0;
            overrun <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                acc[k] <= '0;
                shadow[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (sample_stb && busy)
                overrun <= 1'b1;
            if (state == IDLE) begin
                if (sample_stb) begin
                    in_r <= in;
                    bw_r <= bw;
                    clr_r <= clr;
                    ch <= '0;
                    busy <= 1'b1;
                    state <= RUN;
                end
            end else begin
                acc[ch] <= acc_nx;
                shadow[ch] <= y;
                if (ch == CW'(NCH-1)) begin
                    out <= frame;
                    out_valid <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end else begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/noise_iir_mc.md
NOISE_IIR_MC -- requirements
Module: noise_iir_mc

Interface
REQ-001 Parameter DSZ, 18, signed sample width of inputs and outputs.
REQ-002 Parameter Q, 31, maximum shift coefficient; accumulator width ISZ = DSZ+Q.
REQ-003 Parameter NCH, 4, channel count (1..16).
REQ-004 Port clk  in  1  system clock; all state on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port sample_stb  in  1  frame start request; one-cycle pulse.
REQ-007 Port in  in  NCH*DSZ  signed samples, channel k at bits [k*DSZ +: DSZ].
REQ-008 Port bw  in  NCH*5  per-channel bandwidth, channel k at bits [k*5 +: 5].
REQ-009 Port clr  in  NCH  per-channel accumulator clear, applied during that channel's slot.
REQ-010 Port out  out  NCH*DSZ  signed filtered outputs, same packing as in.
REQ-011 Port out_valid  out  1  one-cycle pulse, new out frame available.
REQ-012 Port busy  out  1  frame in progress.
REQ-013 Port overrun  out  1  sticky; a sample_stb was dropped.

Function
REQ-014 States IDLE and RUN; a channel counter ch (0..NCH-1) is active only in RUN.
REQ-015 In IDLE, sample_stb=1 at edge E0 shall latch in, bw and clr into frame registers, set ch=0, enter RUN, busy=1.
REQ-016 In RUN, edge E(k+1) processes channel k through one shared datapath; exactly one channel per cycle.
REQ-017 coef = Q - bw[k] when bw[k] <= Q, else 0.
REQ-018 fb = acc[k] >>> coef (arithmetic), ISZ bits.
REQ-019 sum = signext(in[k]) + acc[k] - fb, computed at ISZ+1 bits, saturated to ISZ bits, written to acc[k].
REQ-020 If clr[k]=1 in the latched frame, acc[k] shall be written 0 and output k shall be 0.
REQ-021 Output value k = (new acc[k]) >>> coef, saturated to DSZ bits, written to a shadow register.
REQ-022 At E(NCH) the shadow shall be copied to out in one edge, out_valid=1 for the following cycle only, busy=0, state=IDLE.
REQ-023 out shall hold its value between frames; no partially updated frame is ever visible on out.
REQ-024 sample_stb sampled while busy=1 (including at edge E(NCH)) shall be ignored and shall set overrun.
REQ-025 Latency: sample_stb to out_valid = NCH+1 cycles; maximum frame rate one per NCH+1 cycles.
REQ-026 Changes to in, bw, clr during RUN shall not affect the current frame.
REQ-027 coef=0 (bw>=Q) shall give out[k] = in[k] on every frame.

Reset
REQ-028 rst_n=0 shall immediately clear all acc, shadow, out, out_valid, busy, overrun to 0 and state to IDLE.
REQ-029 Reset mid-frame shall abort the frame with no out_valid; the first frame after release starts from zero state.
REQ-030 overrun shall clear only by reset.

Structure
REQ-031 Package noise_iir_pkg holds BW_W=5, the IDLE/RUN state encoding and the default DSZ/Q.
REQ-032 Saturation shall use the existing sat sub-module (isz=ISZ+1, osz=ISZ), plus a second instance (ISZ to DSZ) for output.
REQ-033 Accumulators shall be an NCH-entry register array indexed by ch; one datapath instance only.

Verification (NCH=4, DSZ=18, Q=31)
REQ-034 bw=31 all channels, in={100,-200,300,-400}, one stb -> out_valid 5 cycles later, out equals in exactly.
REQ-035 bw[0]=30, in[0]=1000, stb every 6 cycles -> out[0] sequence 500, 750, 875, 937, converging to 1000.
REQ-036 in[0]=+131071, bw[0]=0, 10^4 frames -> acc never wraps, out[0] monotonic non-decreasing, no sign flip.
REQ-037 stb at E0 and E0+2 -> single out_valid at E0+5, overrun=1, second request has no effect.
REQ-038 Converged channel 2 with clr[2]=1 for one frame -> out[2]=0 that frame, other channels unchanged and continuing.
REQ-039 rst_n low at E0+2 -> busy, out_valid, out all 0 at once, no out_valid after release until a new stb.
